tape_punch_dev: RTL and testbench
=================================

TAPE_PUNCH_DEV -- requirements
Module: tape_punch_dev

Interface
REQ-001 Parameter SYNC_PERIOD, default 64: clocks per punch cycle; SHALL be at least SYNC_WIDTH+2.
REQ-002 Parameter SYNC_WIDTH, default 4: clocks PUNCH_SYNC is high per punch cycle; SHALL be at least 1.
REQ-003 Parameter FIFO_DEPTH, default 8: host FIFO entries; SHALL be a power of 2.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLOCK  in  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 PUNCH_SIGNAL  in  1  punch request from the I/O section.
REQ-008 OB1..OB5  in  1 each  punch code bits from the I/O section; OB1 is LSB, OB5 is MSB.
REQ-009 PUNCH_SYNC  out  1  punch-cycle sync pulse to the I/O section; registered.
REQ-010 PUNCHED_TAPE1..PUNCHED_TAPE5  out  1 each  echo of the last punched code; PUNCHED_TAPE1 is LSB; registered.
REQ-011 host_data  out  5  code at the FIFO head.
REQ-012 host_valid  out  1  FIFO not empty.
REQ-013 host_ready  in  1  host accepts host_data this cycle.
REQ-014 overflow  out  1  sticky flag: a code was dropped.
REQ-015 clr_overflow  in  1  clears overflow.
REQ-016 punch_count  out  16  count of accepted codes.

Function
REQ-017 The FSM SHALL have three states:
- SYNC: SYNC_WIDTH cycles.
- SAMPLE: 1 cycle.
- GAP: SYNC_PERIOD-SYNC_WIDTH-1 cycles.
REQ-018 FSM sequence SHALL be SYNC -> SAMPLE -> GAP -> SYNC, timed by a phase counter that resets to 0 on each state entry.
REQ-019 PUNCH_SYNC SHALL be 1 exactly during the SYNC state.
REQ-020 In SAMPLE, if PUNCH_SIGNAL=1, the block SHALL capture {OB5..OB1} as the code.
REQ-021 In SAMPLE with PUNCH_SIGNAL=0, the block SHALL leave the FIFO, PUNCHED_TAPE and punch_count unchanged.
REQ-022 For a captured code, PUNCHED_TAPE1..5 SHALL show it from the cycle after SAMPLE and hold it until the next capture.
REQ-023 A captured code SHALL be pushed into the FIFO when the FIFO is not full, or when it is full and host_ready=1 in the same cycle.
REQ-024 A captured code SHALL be dropped when the FIFO is full and host_ready=0, and overflow SHALL be set.
REQ-025 punch_count SHALL increment by 1 for every captured code, whether pushed or dropped, and SHALL wrap from 65535 to 0.
REQ-026 A pop SHALL occur when host_valid=1 and host_ready=1; host_ready with an empty FIFO SHALL have no effect.
REQ-027 host_data SHALL equal the FIFO head whenever host_valid=1.
REQ-028 host_valid SHALL be 1 from the cycle after a push into an empty FIFO.
REQ-029 Read and write pointers SHALL be log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, and be tracked by an occupancy count of 0..FIFO_DEPTH.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-031 clr_overflow=1 SHALL clear overflow on the next edge; if an overflow event occurs in the same cycle, set SHALL win.
REQ-032 PUNCH_SIGNAL and OB1..OB5 SHALL be sampled only in SAMPLE; changes at any other time SHALL have no effect.

Reset
REQ-033 While rst_n=0 the block SHALL force:
- FSM = GAP, phase counter = 0.
- PUNCH_SYNC = 0, PUNCHED_TAPE1..5 = 0.
- FIFO emptied, host_valid = 0, host_data = 0.
- overflow = 0, punch_count = 0.
REQ-034 After release, the first PUNCH_SYNC rising edge SHALL occur SYNC_PERIOD-SYNC_WIDTH-1 cycles after the first clock edge.
REQ-035 Reset asserted mid-cycle or mid-transfer SHALL discard FIFO contents and any pending capture without emitting a partial pop.

Verification
REQ-036 Defaults, free-run 200 clocks with PUNCH_SIGNAL=0 -> PUNCH_SYNC high 4 cycles every 64; first rise 59 cycles after reset release; FIFO stays empty.
REQ-037 PUNCH_SIGNAL=1, OB=5'b10110, host_ready=1 -> after SAMPLE: PUNCHED_TAPE=10110, host_valid=1 with host_data=10110 for one cycle, punch_count=1.
REQ-038 host_ready=0, codes 1..9 on 9 consecutive punch cycles -> FIFO holds 1..8, code 9 dropped, overflow=1, punch_count=9; then draining yields 1..8 in order, and host_valid=0 after the 8th pop.
REQ-039 FIFO full with host_ready=1 held across a SAMPLE capturing code 5'h1F -> no overflow, occupancy stays 8, and 5'h1F appears as the last entry.
REQ-040 clr_overflow pulsed in the same cycle as an overflow drop -> overflow remains 1; a later pulse with no drop -> overflow=0.
REQ-041 rst_n pulsed low during GAP with 3 entries queued -> host_valid=0, punch_count=0, PUNCHED_TAPE=0, and PUNCH_SYNC timing restarts as in REQ-034.

Source files
------------

// File: rtl/tape_punch_dev.sv
// ---------------------------------------------------------------------------
// tape_punch_dev
//
// Paper-tape punch device model. It generates a periodic punch-cycle sync
// pulse towards the I/O section. In the single cycle that follows each sync
// pulse, it samples the punch request and the 5-bit punch code. A captured
// code is echoed on PUNCHED_TAPE1..5 and queued in a small host FIFO.
//
// Punch cycle (SYNC_PERIOD clocks in total):
//   SYNC   : SYNC_WIDTH clocks, PUNCH_SYNC = 1
//   SAMPLE : 1 clock, PUNCH_SIGNAL / OB1..OB5 are sampled at its closing edge
//   GAP    : SYNC_PERIOD - SYNC_WIDTH - 1 clocks
// Reset parks the FSM at the start of GAP. The first sync pulse therefore
// rises SYNC_PERIOD - SYNC_WIDTH - 1 edges after reset is released.
//
// Ports
//   CLOCK, rst_n              system clock, asynchronous active-low reset
//   PUNCH_SIGNAL, OB1..OB5    punch request and code (OB1 = LSB)
//   PUNCH_SYNC                registered sync pulse, high during SYNC
//   PUNCHED_TAPE1..5          registered echo of the last captured code
//   host_data/valid/ready     FIFO read side
//                             (valid/ready: a pop happens on an edge where
//                             host_valid and host_ready are both 1; host_data
//                             is the head while host_valid = 1 and is 0
//                             otherwise)
//   overflow, clr_overflow    sticky drop flag and its clear (set wins)
//   punch_count               16-bit wrapping count of captured codes
//   dbg_state                 current FSM state, for observation only
// ---------------------------------------------------------------------------
module tape_punch_dev #(
  parameter int SYNC_PERIOD = 64,
  parameter int SYNC_WIDTH  = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic        PUNCH_SIGNAL,
  input  logic        OB1,
  input  logic        OB2,
  input  logic        OB3,
  input  logic        OB4,
  input  logic        OB5,
  output logic        PUNCH_SYNC,
  output logic        PUNCHED_TAPE1,
  output logic        PUNCHED_TAPE2,
  output logic        PUNCHED_TAPE3,
  output logic        PUNCHED_TAPE4,
  output logic        PUNCHED_TAPE5,
  output logic [4:0]  host_data,
  output logic        host_valid,
  input  logic        host_ready,
  output logic        overflow,
  input  logic        clr_overflow,
  output logic [15:0] punch_count,
  output logic [1:0]  dbg_state
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  localparam int PW        = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int SYNC_LAST = SYNC_WIDTH - 1;
  localparam int GAP_LAST  = SYNC_PERIOD - SYNC_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   phase;

  // -------------------------------------------------------------------------
  // Punch-cycle FSM
  // -------------------------------------------------------------------------
  // The phase counter restarts at 0 on every state entry. PUNCH_SYNC is
  // registered together with the state transition, so it is high for
  // exactly the clocks spent in SYNC.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GAP;
      phase      <= '0;
      PUNCH_SYNC <= 1'b0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (phase == PW'(SYNC_LAST)) begin
            state      <= ST_SAMPLE;
            phase      <= '0;
            PUNCH_SYNC <= 1'b0;
          end else begin
            phase      <= phase + 1'b1;
          end
        end
        ST_SAMPLE: begin
          state      <= ST_GAP;
          phase      <= '0;
          PUNCH_SYNC <= 1'b0;
        end
        ST_GAP: begin
          if (phase == PW'(GAP_LAST)) begin
            state      <= ST_SYNC;
            phase      <= '0;
            PUNCH_SYNC <= 1'b1;
          end else begin
            phase      <= phase + 1'b1;
          end
        end
        default: begin
          state      <= ST_GAP;
          phase      <= '0;
          PUNCH_SYNC <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Capture and FIFO control
  // -------------------------------------------------------------------------
  logic [4:0]    code;
  logic          capture;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW-1:0] occupancy;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [4:0]    mem [0:FIFO_DEPTH-1];

  assign code       = {OB5, OB4, OB3, OB2, OB1};
  // The inputs are only looked at while in SAMPLE.
  assign capture    = (state == ST_SAMPLE) && PUNCH_SIGNAL;
  assign fifo_empty = (occupancy == '0);
  assign fifo_full  = (occupancy == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && host_ready;
  // A full FIFO can still take the code when the head leaves on the same
  // edge; the slot being written is the one being read out.
  assign push       = capture && (!fifo_full || pop);
  assign drop       = capture && fifo_full && !host_ready;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    ptr_next = (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage needs no reset: the entries are only visible through host_data,
  // which is masked while the FIFO is empty.
  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= code;
  end

  assign host_valid = !fifo_empty;
  assign host_data  = host_valid ? mem[rd_ptr] : 5'd0;

  // -------------------------------------------------------------------------
  // Tape echo, punch counter, overflow flag
  // -------------------------------------------------------------------------
  logic [4:0] tape_q;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      tape_q      <= '0;
      punch_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (capture) begin
        tape_q      <= code;
        // The counter counts dropped codes as well and wraps naturally.
        punch_count <= punch_count + 16'd1;
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  assign PUNCHED_TAPE1 = tape_q[0];
  assign PUNCHED_TAPE2 = tape_q[1];
  assign PUNCHED_TAPE3 = tape_q[2];
  assign PUNCHED_TAPE4 = tape_q[3];
  assign PUNCHED_TAPE5 = tape_q[4];

endmodule

// File: tb/tb_tape_punch_dev.sv
// ---------------------------------------------------------------------------
// tb_tape_punch_dev
//
// Bench for tape_punch_dev with the default parameters. A reference model
// tracks the expected device behaviour:
//   - the punch-cycle position is worked out from the number of edges since
//     reset release, using the phase lengths;
//   - the FIFO is a queue of codes;
//   - the tape echo, counter and overflow flag are plain variables.
// Inputs are driven 1 time unit after a rising edge. Outputs are checked
// 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_tape_punch_dev;

  localparam int SYNC_PERIOD = 64;
  localparam int SYNC_WIDTH  = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIRST_SYNC  = SYNC_PERIOD - SYNC_WIDTH - 1;

  logic        CLOCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        PUNCH_SIGNAL = 1'b0;
  logic        OB1 = 1'b0, OB2 = 1'b0, OB3 = 1'b0, OB4 = 1'b0, OB5 = 1'b0;
  logic        PUNCH_SYNC;
  logic        PUNCHED_TAPE1, PUNCHED_TAPE2, PUNCHED_TAPE3;
  logic        PUNCHED_TAPE4, PUNCHED_TAPE5;
  logic [4:0]  host_data;
  logic        host_valid;
  logic        host_ready = 1'b0;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic [15:0] punch_count;
  logic [1:0]  dbg_state;
  logic [4:0]  tape;

  assign tape = {PUNCHED_TAPE5, PUNCHED_TAPE4, PUNCHED_TAPE3,
                 PUNCHED_TAPE2, PUNCHED_TAPE1};

  tape_punch_dev #(
    .SYNC_PERIOD(SYNC_PERIOD),
    .SYNC_WIDTH (SYNC_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLOCK        (CLOCK),
    .rst_n        (rst_n),
    .PUNCH_SIGNAL (PUNCH_SIGNAL),
    .OB1          (OB1),
    .OB2          (OB2),
    .OB3          (OB3),
    .OB4          (OB4),
    .OB5          (OB5),
    .PUNCH_SYNC   (PUNCH_SYNC),
    .PUNCHED_TAPE1(PUNCHED_TAPE1),
    .PUNCHED_TAPE2(PUNCHED_TAPE2),
    .PUNCHED_TAPE3(PUNCHED_TAPE3),
    .PUNCHED_TAPE4(PUNCHED_TAPE4),
    .PUNCHED_TAPE5(PUNCHED_TAPE5),
    .host_data    (host_data),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .punch_count  (punch_count),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 CLOCK = ~CLOCK;

  // Scoreboard and reference model
  logic [4:0]  exp_q[$];
  int          m_n;
  logic [4:0]  m_tape;
  logic [15:0] m_count;
  logic        m_ovf;
  int          n_checks;
  int          n_pass;
  logic [1:0]  gap_state_code;

  // Edge n (counted from reset release) leaves PUNCH_SYNC high when it is
  // one of the first SYNC_WIDTH edges of a punch cycle.
  function automatic logic sync_after(input int n);
    sync_after = (n >= FIRST_SYNC) && (((n - FIRST_SYNC) % SYNC_PERIOD) < SYNC_WIDTH);
  endfunction

  // Edge n samples the inputs when it closes the single SAMPLE clock.
  function automatic logic is_sample_edge(input int n);
    is_sample_edge = (n >= FIRST_SYNC) &&
                     (((n - FIRST_SYNC) % SYNC_PERIOD) == SYNC_WIDTH + 1);
  endfunction

  function automatic logic [4:0] exp_head();
    exp_head = (exp_q.size() > 0) ? exp_q[0] : 5'd0;
  endfunction

  // Driver tasks
  task automatic set_code(input logic [4:0] c);
    {OB5, OB4, OB3, OB2, OB1} = c;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_n     = 0;
    m_tape  = '0;
    m_count = '0;
    m_ovf   = 1'b0;
  endtask

  // Advance one clock. The model is updated from the inputs that the
  // DUT sees on this edge.
  task automatic tick();
    int         sz;
    logic       cap;
    logic       pop;
    logic [4:0] c;
    @(posedge CLOCK);
    m_n++;
    sz  = exp_q.size();
    cap = is_sample_edge(m_n) && PUNCH_SIGNAL;
    pop = (sz > 0) && host_ready;
    c   = {OB5, OB4, OB3, OB2, OB1};
    if (pop) void'(exp_q.pop_front());
    if (cap) begin
      m_count = m_count + 16'd1;
      m_tape  = c;
      if (sz < FIFO_DEPTH || pop) exp_q.push_back(c);
      else                        m_ovf = 1'b1;
    end
    if (!(cap && sz >= FIFO_DEPTH && !pop) && clr_overflow) m_ovf = 1'b0;
    #1;
  endtask

  // Tick until the next edge is a sample edge.
  task automatic run_to_sample();
    while (!is_sample_edge(m_n + 1)) tick();
  endtask

  // Hold reset for some edges, then release it just after an edge.
  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(posedge CLOCK);
    #1;
    rst_n = 1'b1;
  endtask

  // Punch one code on the next punch cycle.
  task automatic punch(input logic [4:0] c, input logic ready_at_sample);
    run_to_sample();
    PUNCH_SIGNAL = 1'b1;
    set_code(c);
    host_ready   = ready_at_sample;
    tick();
    PUNCH_SIGNAL = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge CLOCK);
    #1;
    gap_state_code = dbg_state;
    n_checks++; if (PUNCH_SYNC !== 1'b0) $display("FAIL reset_sync got %b exp 0", PUNCH_SYNC); else n_pass++;
    n_checks++; if (host_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", host_valid); else n_pass++;
    n_checks++; if (host_data !== 5'd0) $display("FAIL reset_data got %h exp 0", host_data); else n_pass++;
    n_checks++; if (tape !== 5'd0) $display("FAIL reset_tape got %b exp 0", tape); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else n_pass++;
    n_checks++; if (punch_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", punch_count); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    int first_rise = -1;
    logic prev = 1'b0;
    PUNCH_SIGNAL = 1'b0;
    for (int i = 0; i < 200; i++) begin
      set_code(5'($urandom_range(0, 31)));
      host_ready = 1'($urandom_range(0, 1));
      tick();
      if (PUNCH_SYNC && !prev && first_rise < 0) first_rise = m_n;
      prev = PUNCH_SYNC;
      n_checks++; if (PUNCH_SYNC !== sync_after(m_n)) $display("FAIL free_sync edge %0d got %b exp %b", m_n, PUNCH_SYNC, sync_after(m_n)); else n_pass++;
      n_checks++; if (host_valid !== 1'b0) $display("FAIL free_valid edge %0d got %b exp 0", m_n, host_valid); else n_pass++;
      if (m_n == 30) begin
        n_checks++; if (dbg_state !== gap_state_code) $display("FAIL free_gap_state got %0d exp %0d", dbg_state, gap_state_code); else n_pass++;
      end
    end
    n_checks++; if (first_rise != FIRST_SYNC) $display("FAIL free_first_rise got %0d exp %0d", first_rise, FIRST_SYNC); else n_pass++;
    n_checks++; if (punch_count !== 16'd0) $display("FAIL free_count got %0d exp 0", punch_count); else n_pass++;
  endtask

  task automatic test_single();
    punch(5'b10110, 1'b1);
    n_checks++; if (tape !== 5'b10110) $display("FAIL single_tape got %b exp 10110", tape); else n_pass++;
    n_checks++; if (host_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", host_valid); else n_pass++;
    n_checks++; if (host_data !== 5'b10110) $display("FAIL single_data got %b exp 10110", host_data); else n_pass++;
    n_checks++; if (punch_count !== m_count || m_count != 16'd1) $display("FAIL single_count got %0d exp 1", punch_count); else n_pass++;
    set_code(5'b01001);
    tick();
    n_checks++; if (host_valid !== 1'b0) $display("FAIL single_popped got %b exp 0", host_valid); else n_pass++;
    n_checks++; if (tape !== 5'b10110) $display("FAIL single_tape_hold got %b exp 10110", tape); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] base = m_count;
    host_ready = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      run_to_sample();
      clr_overflow = (c == 9);
      punch(5'(c), 1'b0);
      clr_overflow = 1'b0;
      n_checks++; if (tape !== 5'(c)) $display("FAIL ovf_tape code %0d got %0d", c, tape); else n_pass++;
      n_checks++; if (punch_count !== m_count) $display("FAIL ovf_count got %0d exp %0d", punch_count, m_count); else n_pass++;
    end
    n_checks++; if (punch_count !== base + 16'd9) $display("FAIL ovf_count9 got %0d exp %0d", punch_count, base + 16'd9); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", overflow); else n_pass++;
    n_checks++; if (overflow !== m_ovf) $display("FAIL ovf_model got %b exp %b", overflow, m_ovf); else n_pass++;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else n_pass++;
    host_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (host_valid !== 1'b1 || host_data !== 5'(i)) $display("FAIL drain_entry %0d got v=%b d=%0d exp v=1 d=%0d", i, host_valid, host_data, i); else n_pass++;
      tick();
    end
    n_checks++; if (host_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", host_valid); else n_pass++;
    host_ready = 1'b0;
  endtask

  task automatic test_full_push();
    int pops = 0;
    logic [4:0] last = '0;
    host_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      punch(5'($urandom_range(0, 30)), 1'b0);
      host_ready = 1'b0;
    end
    punch(5'h1F, 1'b1);
    host_ready = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL full_no_ovf got %b exp 0", overflow); else n_pass++;
    host_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!host_valid) break;
      n_checks++; if (host_data !== exp_head()) $display("FAIL full_drain_data got %h exp %h", host_data, exp_head()); else n_pass++;
      last = host_data;
      pops++;
      tick();
    end
    host_ready = 1'b0;
    n_checks++; if (pops != FIFO_DEPTH) $display("FAIL full_occupancy got %0d exp %0d", pops, FIFO_DEPTH); else n_pass++;
    n_checks++; if (last !== 5'h1F) $display("FAIL full_last got %h exp 1f", last); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10 * SYNC_PERIOD; i++) begin
      PUNCH_SIGNAL = 1'($urandom_range(0, 1));
      set_code(5'($urandom_range(0, 31)));
      host_ready   = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++; if (PUNCH_SYNC !== sync_after(m_n)) $display("FAIL rnd_sync edge %0d got %b exp %b", m_n, PUNCH_SYNC, sync_after(m_n)); else n_pass++;
      n_checks++; if (host_valid !== (exp_q.size() > 0)) $display("FAIL rnd_valid edge %0d got %b exp %b", m_n, host_valid, exp_q.size() > 0); else n_pass++;
      if (exp_q.size() > 0) begin
        n_checks++; if (host_data !== exp_head()) $display("FAIL rnd_data edge %0d got %h exp %h", m_n, host_data, exp_head()); else n_pass++;
      end
      n_checks++; if (tape !== m_tape) $display("FAIL rnd_tape edge %0d got %b exp %b", m_n, tape, m_tape); else n_pass++;
      n_checks++; if (punch_count !== m_count) $display("FAIL rnd_count edge %0d got %0d exp %0d", m_n, punch_count, m_count); else n_pass++;
      n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf edge %0d got %b exp %b", m_n, overflow, m_ovf); else n_pass++;
    end
    PUNCH_SIGNAL = 1'b0;
    host_ready   = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first_rise = -1;
    // Start from a clean FIFO, then queue three codes.
    host_ready = 1'b1;
    repeat (FIFO_DEPTH + 1) tick();
    host_ready = 1'b0;
    for (int i = 0; i < 3; i++) punch(5'($urandom_range(1, 31)), 1'b0);
    repeat (20) tick();
    n_checks++; if (exp_q.size() != 3 || host_valid !== 1'b1) $display("FAIL mid_queued got v=%b exp 1 with %0d entries", host_valid, exp_q.size()); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (host_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", host_valid); else n_pass++;
    n_checks++; if (punch_count !== 16'd0) $display("FAIL mid_count got %0d exp 0", punch_count); else n_pass++;
    n_checks++; if (tape !== 5'd0) $display("FAIL mid_tape got %b exp 0", tape); else n_pass++;
    n_checks++; if (host_data !== 5'd0) $display("FAIL mid_data got %h exp 0", host_data); else n_pass++;
    apply_reset(2);
    for (int i = 0; i < FIRST_SYNC + 10; i++) begin
      tick();
      if (PUNCH_SYNC && first_rise < 0) first_rise = m_n;
      n_checks++; if (PUNCH_SYNC !== sync_after(m_n)) $display("FAIL mid_sync edge %0d got %b exp %b", m_n, PUNCH_SYNC, sync_after(m_n)); else n_pass++;
    end
    n_checks++; if (first_rise != FIRST_SYNC) $display("FAIL mid_first_rise got %0d exp %0d", first_rise, FIRST_SYNC); else n_pass++;
    n_checks++; if (host_valid !== 1'b0) $display("FAIL mid_empty got %b exp 0", host_valid); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    test_reset();
    apply_reset(2);
    test_free_run();
    test_single();
    test_overflow();
    test_full_push();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
